bus_regfile_ctrl: RTL and testbench

Parametrised register bank with an accumulator on one shared internal data bus.
- Transfers are sequenced by an on-chip FSM, not by per-module select/read-write pins.
- Host issues one operation per Start: write, read, register-to-register move, accumulator load/add/store/clear.
- Sits between the external pad interface and the datapath. The top level builds the bidirectional pad from DinExt, DoutExt and DoutEn.

---
 rtl/bus_regfile_ctrl_pkg.sv | 34 +++
 rtl/bus_regfile_ctrl_reg_bank.sv | 40 ++++
 rtl/bus_regfile_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bus_regfile_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_regfile_ctrl_pkg.sv
// Shared types for the bus register-file controller: op codes, FSM states
// and small op-classification helpers used by the controller.
package bus_regfile_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 3'b000,
    OP_WRITE  = 3'b001,
    OP_READ   = 3'b010,
    OP_MOVE   = 3'b011,
    OP_LDACC  = 3'b100,
    OP_ADDACC = 3'b101,
    OP_STACC  = 3'b110,
    OP_CLRACC = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUS    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Ops whose bus source is a general register selected by SrcAddr.
  function automatic logic op_reads_reg(op_t op);
    return op inside {OP_READ, OP_MOVE, OP_LDACC, OP_ADDACC};
  endfunction

  // Ops whose destination is a general register selected by DstAddr.
  function automatic logic op_writes_reg(op_t op);
    return op inside {OP_WRITE, OP_MOVE, OP_STACC};
  endfunction

endpackage

// File: rtl/bus_regfile_ctrl_reg_bank.sv
// NREG x WIDTH general register array: one combinational read port, one
// synchronous write port. Addresses beyond NREG read as 0 and never write;
// the controller is responsible for flagging them.
module reg_bank #(
  parameter int WIDTH  = 8,
  parameter int NREG   = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
);

  logic [WIDTH-1:0] mem [NREG];

  // Read port: decoded compare per entry so an unused address code never
  // indexes past the array.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = mem[i];
    end
  end

  // Write port with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_addr == ADDR_W'(i)) mem[i] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/bus_regfile_ctrl.sv
// Register bank plus accumulator on one internal bus, sequenced by a
// three-state FSM. One host operation per Start; Done/Err pulse in the
// first IDLE cycle after COMMIT.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for Start; request fields latched on acceptance
//   BUS    | one source drives the bus, value captured into bus_q
//   COMMIT | destination updated from bus_q, Done/Err raised for next cycle
module bus_regfile_ctrl
  import bus_regfile_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NREG   = 4,
  parameter int ADDR_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [OP_W-1:0]   Op,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [WIDTH-1:0]  DinExt,
  output logic [WIDTH-1:0]  DoutExt,
  output logic              DoutEn,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [WIDTH-1:0]  AccOut,
  output logic              Carry
);

  // One extra bit so NREG itself is representable for the range compare.
  localparam logic [ADDR_W:0] NREG_LIM = (ADDR_W + 1)'(NREG);

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [WIDTH-1:0]  din_q;
  logic [WIDTH-1:0]  bus_q;
  logic [WIDTH-1:0]  acc;
  logic              carry;
  logic [WIDTH-1:0]  dout;
  logic              dout_en;
  logic              busy;
  logic              done;
  logic              err;

  logic              src_ok;
  logic              dst_ok;
  logic              addr_err;
  logic              bank_we;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  bus_val;
  logic [WIDTH:0]    sum;

  assign src_ok   = {1'b0, src_q} < NREG_LIM;
  assign dst_ok   = {1'b0, dst_q} < NREG_LIM;
  assign addr_err = (op_reads_reg(op_q) && !src_ok) ||
                    (op_writes_reg(op_q) && !dst_ok);
  assign bank_we  = (state == COMMIT) && op_writes_reg(op_q) && dst_ok;
  assign sum      = {1'b0, acc} + {1'b0, bus_q};

  reg_bank #(
    .WIDTH  (WIDTH),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_reg_bank (
    .clk     (Clock),
    .rst     (Reset),
    .rd_addr (src_q),
    .rd_data (rd_data),
    .wr_en   (bank_we),
    .wr_addr (dst_q),
    .wr_data (bus_q)
  );

  // Internal bus mux: exactly one source per op, 0 when nothing drives it.
  always_comb begin
    bus_val = '0;
    case (op_q)
      OP_WRITE:                               bus_val = din_q;
      OP_READ, OP_MOVE, OP_LDACC, OP_ADDACC:  bus_val = src_ok ? rd_data : '0;
      OP_STACC:                               bus_val = acc;
      default:                                bus_val = '0;
    endcase
  end

  // Sequencer with registered handshake, accumulator and pad outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      op_q    <= OP_NOP;
      src_q   <= '0;
      dst_q   <= '0;
      din_q   <= '0;
      bus_q   <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      dout    <= '0;
      dout_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_q    <= op_t'(Op);
            src_q   <= SrcAddr;
            dst_q   <= DstAddr;
            din_q   <= DinExt;
            dout_en <= 1'b0;
            busy    <= 1'b1;
            state   <= BUS;
          end
        end
        BUS: begin
          bus_q <= bus_val;
          state <= COMMIT;
        end
        COMMIT: begin
          case (op_q)
            OP_READ: begin
              dout    <= bus_q;
              dout_en <= 1'b1;
            end
            OP_LDACC: begin
              acc   <= bus_q;
              carry <= 1'b0;
            end
            OP_ADDACC: begin
              acc   <= sum[WIDTH-1:0];
              carry <= sum[WIDTH];
            end
            OP_CLRACC: begin
              acc   <= '0;
              carry <= 1'b0;
            end
            default: ;
          endcase
          done  <= 1'b1;
          err   <= addr_err;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign DoutExt = dout;
  assign DoutEn  = dout_en;
  assign Busy    = busy;
  assign Done    = done;
  assign Err     = err;
  assign AccOut  = acc;
  assign Carry   = carry;

endmodule

// File: tb/tb_bus_regfile_ctrl.sv
// Bench for bus_regfile_ctrl: two instances (NREG=4 and NREG=3) share one
// stimulus stream; each is compared against an op-level reference model.
module tb_bus_regfile_ctrl;
  import bus_regfile_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [2:0] Op;
  logic [1:0] SrcAddr;
  logic [1:0] DstAddr;
  logic [7:0] DinExt;

  logic [7:0] dout_a, acc_a, dout_b, acc_b;
  logic       douten_a, busy_a, done_a, err_a, carry_a;
  logic       douten_b, busy_b, done_b, err_b, carry_b;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  bus_regfile_ctrl #(.WIDTH(8), .NREG(4)) dut_a (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .DinExt(DinExt),
    .DoutExt(dout_a), .DoutEn(douten_a), .Busy(busy_a), .Done(done_a),
    .Err(err_a), .AccOut(acc_a), .Carry(carry_a)
  );

  bus_regfile_ctrl #(.WIDTH(8), .NREG(3)) dut_b (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .DinExt(DinExt),
    .DoutExt(dout_b), .DoutEn(douten_b), .Busy(busy_b), .Done(done_b),
    .Err(err_b), .AccOut(acc_b), .Carry(carry_b)
  );

  // ---------------- reference model (per instance, op level) -------------
  logic [7:0] m_reg [2][4];
  logic [7:0] m_acc [2];
  logic [7:0] m_dout[2];
  logic       m_carry[2];
  logic       m_en  [2];
  logic       m_err [2];
  int         nreg_of[2] = '{4, 3};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 4; r++) m_reg[k][r] = 8'h00;
      m_acc[k] = 8'h00; m_dout[k] = 8'h00;
      m_carry[k] = 1'b0; m_en[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_op(input logic [2:0] op, input logic [1:0] src,
                          input logic [1:0] dst, input logic [7:0] din);
    int         n;
    logic [7:0] sv;
    logic [8:0] s;
    bit         src_bad, dst_bad;
    for (int k = 0; k < 2; k++) begin
      n       = nreg_of[k];
      src_bad = int'(src) >= n;
      dst_bad = int'(dst) >= n;
      sv      = src_bad ? 8'h00 : m_reg[k][src];
      m_en[k] = 1'b0;
      m_err[k] = 1'b0;
      case (op)
        3'b001: begin if (!dst_bad) m_reg[k][dst] = din; m_err[k] = dst_bad; end
        3'b010: begin m_dout[k] = sv; m_en[k] = 1'b1; m_err[k] = src_bad; end
        3'b011: begin if (!dst_bad) m_reg[k][dst] = sv; m_err[k] = src_bad | dst_bad; end
        3'b100: begin m_acc[k] = sv; m_carry[k] = 1'b0; m_err[k] = src_bad; end
        3'b101: begin
          s = {1'b0, m_acc[k]} + {1'b0, sv};
          m_acc[k] = s[7:0]; m_carry[k] = s[8]; m_err[k] = src_bad;
        end
        3'b110: begin if (!dst_bad) m_reg[k][dst] = m_acc[k]; m_err[k] = dst_bad; end
        3'b111: begin m_acc[k] = 8'h00; m_carry[k] = 1'b0; end
        default: ;
      endcase
    end
  endtask

  // ---------------- comparison helpers -----------------------------------
  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk8({tag, "_dout_a"},  dout_a,   m_dout[0]);
    chk1({tag, "_en_a"},    douten_a, m_en[0]);
    chk8({tag, "_acc_a"},   acc_a,    m_acc[0]);
    chk1({tag, "_carry_a"}, carry_a,  m_carry[0]);
    chk1({tag, "_err_a"},   err_a,    m_err[0]);
    chk8({tag, "_dout_b"},  dout_b,   m_dout[1]);
    chk1({tag, "_en_b"},    douten_b, m_en[1]);
    chk8({tag, "_acc_b"},   acc_b,    m_acc[1]);
    chk1({tag, "_carry_b"}, carry_b,  m_carry[1]);
    chk1({tag, "_err_b"},   err_b,    m_err[1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk8({tag, "_dout_a"}, dout_a, 8'h00);   chk8({tag, "_acc_a"}, acc_a, 8'h00);
    chk1({tag, "_en_a"},   douten_a, 1'b0);  chk1({tag, "_busy_a"}, busy_a, 1'b0);
    chk1({tag, "_done_a"}, done_a, 1'b0);    chk1({tag, "_err_a"}, err_a, 1'b0);
    chk1({tag, "_carry_a"}, carry_a, 1'b0);
    chk8({tag, "_dout_b"}, dout_b, 8'h00);   chk8({tag, "_acc_b"}, acc_b, 8'h00);
    chk1({tag, "_busy_b"}, busy_b, 1'b0);    chk1({tag, "_done_b"}, done_b, 1'b0);
  endtask

  // Idle cycles: nothing in flight, no stray Done.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      chk1("idle_done_a", done_a, 1'b0);
      chk1("idle_busy_a", busy_a, 1'b0);
      chk1("idle_done_b", done_b, 1'b0);
    end
  endtask

  // Issue one op starting at the current negedge; returns at the negedge
  // where Done is seen, so an immediate next call is a back-to-back Start.
  // poke re-asserts Start (as a WRITE R0=EE) while the op is busy.
  task automatic do_op(input logic [2:0] op, input logic [1:0] src,
                       input logic [1:0] dst, input logic [7:0] din, input bit poke);
    int lat  = 0;
    bit seen = 0;
    model_op(op, src, dst, din);
    Start = 1'b1; Op = op; SrcAddr = src; DstAddr = dst; DinExt = din;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge Clock);
      if (poke && c < 3) begin
        Start = 1'b1; Op = 3'b001; DstAddr = 2'd0; DinExt = 8'hEE;
      end else begin
        Start = 1'b0;
      end
      if (c == 1) begin
        chk1("bus_busy_a", busy_a, 1'b1);
        chk1("bus_douten_a", douten_a, 1'b0);
      end
      if (c == 2) begin
        chk1("commit_busy_a", busy_a, 1'b1);
        chk1("commit_done_a", done_a, 1'b0);
      end
      if (done_a === 1'b1) begin
        seen = 1;
        lat  = c;
      end
    end
    Start = 1'b0;
    chki("done_latency", lat, 3);
    if (seen) begin
      chk1("done_b_aligned", done_b, 1'b1);
      chk1("done_busy_a", busy_a, 1'b0);
      check_model("op");
    end
  endtask

  // ---------------- directed vector table --------------------------------
  typedef struct {
    logic [2:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [7:0] din;
    int         gap;
    logic [7:0] dout_a;
    logic       en;
    logic [7:0] acc_a;
    logic       carry_a;
    logic       err_a;
    logic [7:0] dout_b;
    logic       err_b;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl[NV];

  initial begin
    // op, src, dst, din, gap | dout_a, en, acc_a, carry_a, err_a, dout_b, err_b
    tbl[0]  = '{3'b001, 2'd0, 2'd2, 8'hA5, 1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{3'b010, 2'd2, 2'd0, 8'h99, 1, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[2]  = '{3'b001, 2'd0, 2'd0, 8'hF0, 1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[3]  = '{3'b100, 2'd0, 2'd0, 8'h00, 1, 8'hA5, 1'b0, 8'hF0, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[4]  = '{3'b001, 2'd0, 2'd1, 8'h20, 1, 8'hA5, 1'b0, 8'hF0, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[5]  = '{3'b101, 2'd1, 2'd0, 8'h00, 1, 8'hA5, 1'b0, 8'h10, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[6]  = '{3'b111, 2'd0, 2'd0, 8'h00, 1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[7]  = '{3'b001, 2'd0, 2'd3, 8'h3C, 0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1};
    tbl[8]  = '{3'b011, 2'd3, 2'd1, 8'h00, 0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1};
    tbl[9]  = '{3'b010, 2'd1, 2'd0, 8'h00, 0, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{3'b000, 2'd0, 2'd0, 8'h00, 1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{3'b011, 2'd2, 2'd2, 8'h00, 1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{3'b010, 2'd2, 2'd0, 8'h00, 1, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[13] = '{3'b100, 2'd3, 2'd0, 8'h00, 1, 8'hA5, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1};
    tbl[14] = '{3'b110, 2'd0, 2'd2, 8'h00, 1, 8'hA5, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0};
    tbl[15] = '{3'b010, 2'd2, 2'd0, 8'h00, 1, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[16] = '{3'b001, 2'd0, 2'd3, 8'h77, 1, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[17] = '{3'b010, 2'd3, 2'd0, 8'h00, 1, 8'h77, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[18] = '{3'b101, 2'd0, 2'd0, 8'h00, 1, 8'h77, 1'b0, 8'h2C, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[19] = '{3'b001, 2'd0, 2'd0, 8'h01, 1, 8'h77, 1'b0, 8'h2C, 1'b1, 1'b0, 8'h00, 1'b0};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------------------------------
  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 3'b000;
    SrcAddr = 2'd0; DstAddr = 2'd0; DinExt = 8'h00;
    model_reset();
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check_reset_outputs("reset");

    // Directed table: basic ops, accumulator carry, back-to-back, NREG=3 range.
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].gap > 0) idle(tbl[i].gap);
      do_op(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].din, 1'b0);
      chk8("tbl_dout_a",  dout_a,   tbl[i].dout_a);
      chk1("tbl_en_a",    douten_a, tbl[i].en);
      chk8("tbl_acc_a",   acc_a,    tbl[i].acc_a);
      chk1("tbl_carry_a", carry_a,  tbl[i].carry_a);
      chk1("tbl_err_a",   err_a,    tbl[i].err_a);
      chk8("tbl_dout_b",  dout_b,   tbl[i].dout_b);
      chk1("tbl_err_b",   err_b,    tbl[i].err_b);
    end

    // Start pulsed while busy: ignored, single Done, R0 untouched.
    idle(1);
    do_op(3'b010, 2'd0, 2'd0, 8'h00, 1'b1);
    chk8("poke_dout_a", dout_a, 8'h01);
    idle(4);
    do_op(3'b010, 2'd0, 2'd0, 8'h00, 1'b0);
    chk8("poke_r0_a", dout_a, 8'h01);
    chk8("poke_r0_b", dout_b, 8'h01);

    // Reset during the BUS cycle of WRITE R0=55: aborted, no Done.
    idle(1);
    Start = 1'b1; Op = 3'b001; DstAddr = 2'd0; SrcAddr = 2'd0; DinExt = 8'h55;
    @(negedge Clock);
    Start = 1'b0;
    chk1("abort_in_bus", busy_a, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    check_reset_outputs("abort");
    idle(4);
    do_op(3'b010, 2'd0, 2'd0, 8'h00, 1'b0);
    chk8("abort_r0_a", dout_a, 8'h00);

    // Randomized ops against the model.
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
      do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 4) == 0));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
